// File: rtl/inst_fetch_unit_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD, S_HALT} fetch_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam logic [31:0] INST_NOP = 32'h0;
endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding i-cache fetcher pushing up to two instructions per group into the issue FIFO
import fetch_pkg::*;
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_full,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        fifo_rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata1,
  input  logic [31:0] inst_rdata2,
  output logic        write_en1,
  output logic        write_en2,
  output logic [31:0] write_address1,
  output logic [31:0] write_address2,
  output logic [31:0] write_data1,
  output logic [31:0] write_data2
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic group_end;
  assign group_end = req_pc_q[2];
  assign fifo_rst = rst | redirect_en;
  assign inst_addr = pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    inst_req       = 1'b0;
    write_en1      = 1'b0;
    write_en2      = 1'b0;
    write_address1 = '0;
    write_address2 = '0;
    write_data1    = '0;
    write_data2    = '0;
    if (rst) begin
      state_d = state_q;
    end else if (redirect_en) begin
      pc_d    = redirect_pc;
      state_d = ((state_q == S_WAIT || state_q == S_DISCARD) && !inst_data_ok) ? S_DISCARD : S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (pc_q[1:0] == 2'b00) begin
            inst_req = !fifo_full;
            if (inst_req && inst_addr_ok) begin
              req_pc_d = pc_q;
              pc_d     = pc_q + (pc_q[2] ? 32'd4 : 32'd8);
              state_d  = S_WAIT;
            end
          end else if (!fifo_full) begin
            write_en1      = 1'b1;
            write_address1 = pc_q;
            write_data1    = INST_NOP;
            state_d        = S_HALT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            write_en1      = 1'b1;
            write_en2      = !group_end;
            write_address1 = req_pc_q;
            write_address2 = group_end ? 32'h0 : req_pc_q + 32'd4;
            write_data1    = inst_rdata1;
            write_data2    = group_end ? 32'h0 : inst_rdata2;
            state_d        = S_REQ;
          end
        end
        S_DISCARD: state_d = inst_data_ok ? S_REQ : S_DISCARD;
        S_HALT:    state_d = S_HALT;
      endcase
    end
  end
endmodule
